// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, bus widths and arbiter states
package sdram_pkg;

   localparam int SDRAM_ADDR_W = 13;
   localparam int SDRAM_BA_W   = 2;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_MRS  = 4'b0000;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_RD   = 4'b0101;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARBIT = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } arb_state_t;

endpackage

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command-bus arbiter: grants refresh/write/read, muxes pins, owns DQ
// Optional SDRAM_ARBIT_RR_EN: round-robin between write and read instead of fixed priority.
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter logic [3:0] CMD_NOP = sdram_pkg::CMD_NOP,
   parameter int         DATA_W  = 16
) (
   input  logic                    clk_100M,
   input  logic                    locked_rst_n,
   input  logic                    init_end,
   input  logic [3:0]              init_cmd,
   input  logic [SDRAM_ADDR_W-1:0] init_addr,
   input  logic [SDRAM_BA_W-1:0]   init_ba,
   input  logic                    aref_req,
   input  logic                    aref_end,
   input  logic [3:0]              aref_cmd,
   input  logic [SDRAM_ADDR_W-1:0] aref_addr,
   input  logic [SDRAM_BA_W-1:0]   aref_ba,
   input  logic                    wr_req,
   input  logic                    wr_end,
   input  logic [3:0]              wr_cmd,
   input  logic [SDRAM_ADDR_W-1:0] wr_addr,
   input  logic [SDRAM_BA_W-1:0]   wr_ba,
   input  logic                    wr_sdram_en,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    rd_req,
   input  logic                    rd_end,
   input  logic [3:0]              rd_cmd,
   input  logic [SDRAM_ADDR_W-1:0] rd_addr,
   input  logic [SDRAM_BA_W-1:0]   rd_ba,
   output logic                    aref_en,
   output logic                    wr_en,
   output logic                    rd_en,
   output logic                    sdram_cke,
   output logic                    sdram_cs_n,
   output logic                    sdram_ras_n,
   output logic                    sdram_cas_n,
   output logic                    sdram_we_n,
   output logic [SDRAM_BA_W-1:0]   sdram_ba,
   output logic [SDRAM_ADDR_W-1:0] sdram_addr,
   inout  wire  [DATA_W-1:0]       sdram_dq
);

   arb_state_t state;
   arb_state_t state_nxt;
   logic       pick_rd;
   logic [3:0] cmd;

`ifdef SDRAM_ARBIT_RR_EN
   logic last_wr;

   always_ff @(posedge clk_100M or negedge locked_rst_n) begin
      if (!locked_rst_n) begin
         last_wr <= 1'b0;
      end else if (state == ST_ARBIT && state_nxt == ST_WRITE) begin
         last_wr <= 1'b1;
      end else if (state == ST_ARBIT && state_nxt == ST_READ) begin
         last_wr <= 1'b0;
      end
   end

   assign pick_rd = rd_req && (!wr_req || last_wr);
`else
   assign pick_rd = rd_req && !wr_req;
`endif

   always_ff @(posedge clk_100M or negedge locked_rst_n) begin
      if (!locked_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (state != ST_IDLE && !init_end) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (init_end) state_nxt = ST_ARBIT;
            ST_ARBIT: begin
               // refresh always outranks data traffic
               if (aref_req)     state_nxt = ST_AREF;
               else if (pick_rd) state_nxt = ST_READ;
               else if (wr_req)  state_nxt = ST_WRITE;
            end
            ST_AREF:  if (aref_end) state_nxt = ST_ARBIT;
            ST_WRITE: if (wr_end)   state_nxt = ST_ARBIT;
            ST_READ:  if (rd_end)   state_nxt = ST_ARBIT;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   assign aref_en = (state == ST_AREF);
   assign wr_en   = (state == ST_WRITE);
   assign rd_en   = (state == ST_READ);

   always_comb begin
      cmd        = CMD_NOP;
      sdram_addr = '0;
      sdram_ba   = '0;
      case (state)
         ST_IDLE:  begin cmd = init_cmd; sdram_addr = init_addr; sdram_ba = init_ba; end
         ST_AREF:  begin cmd = aref_cmd; sdram_addr = aref_addr; sdram_ba = aref_ba; end
         ST_WRITE: begin cmd = wr_cmd;   sdram_addr = wr_addr;   sdram_ba = wr_ba;   end
         ST_READ:  begin cmd = rd_cmd;   sdram_addr = rd_addr;   sdram_ba = rd_ba;   end
         default:  ;
      endcase
   end

   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
   assign sdram_cke = 1'b1;

   assign sdram_dq = (wr_en && wr_sdram_en) ? wr_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - self-checking bench for sdram_arbit: vector table, corner sequences, random vs model
module tb_sdram_arbit;
   import sdram_pkg::*;

   logic clk_100M = 1'b0;
   always #5 clk_100M = ~clk_100M;

   logic        locked_rst_n, init_end;
   logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
   logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
   logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
   logic        aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en;
   logic [15:0] wr_data;
   logic        aref_en, wr_en, rd_en, sdram_cke;
   logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_addr;
   wire  [15:0] sdram_dq;

   // undriven DQ reads back as all ones
   for (genvar g = 0; g < 16; g++) begin : g_pu
      pullup (sdram_dq[g]);
   end

   sdram_arbit dut (
      .clk_100M(clk_100M), .locked_rst_n(locked_rst_n), .init_end(init_end),
      .init_cmd(init_cmd), .init_addr(init_addr), .init_ba(init_ba),
      .aref_req(aref_req), .aref_end(aref_end),
      .aref_cmd(aref_cmd), .aref_addr(aref_addr), .aref_ba(aref_ba),
      .wr_req(wr_req), .wr_end(wr_end),
      .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
      .wr_sdram_en(wr_sdram_en), .wr_data(wr_data),
      .rd_req(rd_req), .rd_end(rd_end),
      .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
      .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
      .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
      .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
      .sdram_ba(sdram_ba), .sdram_addr(sdram_addr), .sdram_dq(sdram_dq)
   );

   int errors = 0;
   int checks = 0;

   // model: owner -1 = uninitialised, 0 = between operations, 1 = refresh, 2 = write, 3 = read
   int owner = -1;
   bit last_wr = 1'b0;

   typedef struct {
      logic       ie, a_req, a_end, w_req, w_end, r_req, r_end, w_en;
      logic [2:0] exp_en;
      int         exp_src;
      logic [15:0] exp_dq;
   } vec_t;

   vec_t vecs[22];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [18:0] pins_for(input int src);
      case (src)
         -1:      return {init_cmd, init_addr, init_ba};
         1:       return {aref_cmd, aref_addr, aref_ba};
         2:       return {wr_cmd, wr_addr, wr_ba};
         3:       return {rd_cmd, rd_addr, rd_ba};
         default: return {4'b0111, 13'h0, 2'b00};
      endcase
   endfunction

   function automatic logic [18:0] pins_act();
      return {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_addr, sdram_ba};
   endfunction

   function automatic int choose();
      if (aref_req) return 1;
`ifdef SDRAM_ARBIT_RR_EN
      if (wr_req && rd_req) return last_wr ? 3 : 2;
`endif
      if (wr_req) return 2;
      if (rd_req) return 3;
      return 0;
   endfunction

   task automatic model_edge();
      logic [3:0] ends;
      ends = {rd_end, wr_end, aref_end, 1'b0};
      if (!locked_rst_n) begin
         owner = -1;
         last_wr = 1'b0;
      end else if (owner != -1 && !init_end) begin
         owner = -1;
      end else if (owner == -1) begin
         if (init_end) owner = 0;
      end else if (owner == 0) begin
         owner = choose();
         if (owner == 2) last_wr = 1'b1;
         if (owner == 3) last_wr = 1'b0;
      end else if (ends[owner]) begin
         owner = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk_100M);
      model_edge();
      @(negedge clk_100M);
   endtask

   task automatic check_model(input string tag);
      logic [2:0] eg;
      eg = {owner == 1, owner == 2, owner == 3};
      chk({tag, "_grant"}, {61'h0, aref_en, wr_en, rd_en}, {61'h0, eg});
      chk({tag, "_pins"}, {44'h0, sdram_cke, pins_act()}, {44'h0, 1'b1, pins_for(owner)});
      chk({tag, "_dq"}, {48'h0, sdram_dq},
          {48'h0, (owner == 2 && wr_sdram_en) ? wr_data : 16'hFFFF});
   endtask

   task automatic set_reqs(input logic [7:0] v);
      {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en} = v;
   endtask

   initial begin
      // ie a_req a_end w_req w_end r_req r_end w_en | exp {aref,wr,rd} | bus | dq
      vecs[0]  = '{0,0,0,0,0,0,0,0, 3'b000, -1, 16'hFFFF};
      vecs[1]  = '{1,0,0,0,0,0,0,0, 3'b000, -1, 16'hFFFF};
      vecs[2]  = '{1,1,0,0,0,0,0,0, 3'b000,  0, 16'hFFFF};
      vecs[3]  = '{1,0,0,0,0,0,0,0, 3'b100,  1, 16'hFFFF};
      vecs[4]  = '{1,0,1,0,0,0,0,0, 3'b100,  1, 16'hFFFF};
      vecs[5]  = '{1,0,0,0,0,0,0,0, 3'b000,  0, 16'hFFFF};
      vecs[6]  = '{1,1,0,1,0,1,0,0, 3'b000,  0, 16'hFFFF};
      vecs[7]  = '{1,1,0,1,0,1,0,0, 3'b100,  1, 16'hFFFF};
      vecs[8]  = '{1,0,1,1,0,1,0,0, 3'b100,  1, 16'hFFFF};
      vecs[9]  = '{1,0,0,1,0,1,0,0, 3'b000,  0, 16'hFFFF};
      vecs[10] = '{1,0,0,1,0,1,0,1, 3'b010,  2, 16'hA5A5};
      vecs[11] = '{1,0,0,0,1,1,0,1, 3'b010,  2, 16'hA5A5};
      vecs[12] = '{1,0,0,0,0,1,0,1, 3'b000,  0, 16'hFFFF};
      vecs[13] = '{1,0,0,0,0,1,0,1, 3'b001,  3, 16'hFFFF};
      vecs[14] = '{1,0,0,0,0,0,1,1, 3'b001,  3, 16'hFFFF};
      vecs[15] = '{1,0,0,0,1,0,0,0, 3'b000,  0, 16'hFFFF};
      vecs[16] = '{1,0,1,0,0,0,0,0, 3'b000,  0, 16'hFFFF};
      vecs[17] = '{1,0,0,1,0,0,0,0, 3'b000,  0, 16'hFFFF};
      vecs[18] = '{0,0,0,0,0,0,0,0, 3'b010,  2, 16'hFFFF};
      vecs[19] = '{0,0,0,0,0,0,0,0, 3'b000, -1, 16'hFFFF};
      vecs[20] = '{1,0,0,0,0,0,0,0, 3'b000, -1, 16'hFFFF};
      vecs[21] = '{1,0,0,0,0,0,0,0, 3'b000,  0, 16'hFFFF};

      locked_rst_n = 1'b0;
      set_reqs(8'h00);
      init_cmd = CMD_PRE;  init_addr = 13'h0400; init_ba = 2'b01;
      aref_cmd = CMD_AREF; aref_addr = 13'h1111; aref_ba = 2'b10;
      wr_cmd   = CMD_WR;   wr_addr   = 13'h0ABC; wr_ba   = 2'b11;
      rd_cmd   = CMD_RD;   rd_addr   = 13'h1234; rd_ba   = 2'b01;
      wr_data  = 16'hA5A5;
      @(negedge clk_100M);
      tick();
      #1;
      chk("reset_grants", {61'h0, aref_en, wr_en, rd_en}, 64'h0);
      chk("reset_pins", {44'h0, sdram_cke, pins_act()}, {44'h0, 1'b1, pins_for(-1)});
      chk("reset_dq", {48'h0, sdram_dq}, 64'hFFFF);
      @(negedge clk_100M);
      locked_rst_n = 1'b1;

      // directed vector table
      foreach (vecs[i]) begin
         set_reqs({vecs[i].ie, vecs[i].a_req, vecs[i].a_end, vecs[i].w_req,
                   vecs[i].w_end, vecs[i].r_req, vecs[i].r_end, vecs[i].w_en});
         #1;
         chk($sformatf("vec%0d_grant", i), {61'h0, aref_en, wr_en, rd_en}, {61'h0, vecs[i].exp_en});
         chk($sformatf("vec%0d_pins", i), {45'h0, pins_act()}, {45'h0, pins_for(vecs[i].exp_src)});
         chk($sformatf("vec%0d_dq", i), {48'h0, sdram_dq}, {48'h0, vecs[i].exp_dq});
         tick();
      end

      // async reset while a write is granted
      set_reqs(8'b1001_0000);
      tick();
      set_reqs(8'b1000_0000);
      #1;
      chk("pre_rst_wr_en", {63'h0, wr_en}, 64'h1);
      locked_rst_n = 1'b0;
      #1;
      chk("async_rst_grants", {61'h0, aref_en, wr_en, rd_en}, 64'h0);
      chk("async_rst_pins", {45'h0, pins_act()}, {45'h0, pins_for(-1)});
      tick();
      locked_rst_n = 1'b1;
      init_end = 1'b0;
      tick();
      #1;
      chk("post_rst_idle", {45'h0, pins_act()}, {45'h0, pins_for(-1)});
      init_end = 1'b1;
      tick();
      #1;
      chk("post_rst_arbit", {45'h0, pins_act()}, {45'h0, pins_for(0)});

      // write and read both held for four operations
      begin
         logic [1:0] exp_seq[4];
         bit got;
`ifdef SDRAM_ARBIT_RR_EN
         exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
         exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
         wr_req = 1'b1;
         rd_req = 1'b1;
         for (int op = 0; op < 4; op++) begin
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
               tick();
               #1;
               got = wr_en | rd_en;
            end
            chk($sformatf("rr_op%0d_grant", op), {62'h0, wr_en, rd_en}, {62'h0, exp_seq[op]});
            if (!got) break;
            wr_end = wr_en;
            rd_end = rd_en;
            tick();
            wr_end = 1'b0;
            rd_end = 1'b0;
         end
         wr_req = 1'b0;
         rd_req = 1'b0;
         tick();
      end

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         locked_rst_n = ($urandom_range(0, 499) != 0);
         init_end     = ($urandom_range(0, 99) > 2);
         aref_req     = ($urandom_range(0, 9) == 0);
         aref_end     = ($urandom_range(0, 3) == 0);
         wr_req       = $urandom_range(0, 1) == 1;
         wr_end       = ($urandom_range(0, 3) == 0);
         rd_req       = $urandom_range(0, 1) == 1;
         rd_end       = ($urandom_range(0, 3) == 0);
         wr_sdram_en  = $urandom_range(0, 1) == 1;
         wr_data      = 16'($urandom);
         {init_cmd, init_addr, init_ba} = 19'($urandom);
         {aref_cmd, aref_addr, aref_ba} = 19'($urandom);
         {wr_cmd, wr_addr, wr_ba}       = 19'($urandom);
         {rd_cmd, rd_addr, rd_ba}       = 19'($urandom);
         #1;
         if (!locked_rst_n) begin
            owner = -1;
            last_wr = 1'b0;
         end
         check_model("rand");
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
